switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 98 +++++++++
 tb/tb_switch_debouncer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-channel two-flop synchronizer followed by a
// saturating persistence counter. A channel's debounced level only moves
// after its synchronized input has differed from it for DEBOUNCE_CYCLES
// consecutive enabled cycles. Each accepted edge produces a registered
// one-cycle rise or fall pulse, and a combined change flag.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 32'd8,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd10_000,
  parameter int unsigned CNT_W           = 32'd24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  // Terminal count: reaching it while still differing means acceptance.
  localparam logic [CNT_W-1:0] LP_TERM = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(32'd1);

  logic [WIDTH-1:0]            r_s1;
  logic [WIDTH-1:0]            r_s2;
  logic [WIDTH-1:0]            r_stable;
  logic [WIDTH-1:0]            r_rise;
  logic [WIDTH-1:0]            r_fall;
  logic                        r_changed;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]            w_stable_nxt;
  logic [WIDTH-1:0]            w_rise_nxt;
  logic [WIDTH-1:0]            w_fall_nxt;
  logic                        w_changed_nxt;

  // Synchronizer: keeps sampling whenever out of reset, independent of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_in;
      r_s2 <= r_s1;
    end
  end

  // Per-channel persistence counting and acceptance decision.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_rise_nxt   = '0;
    w_fall_nxt   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!ena) begin
        // Disabled: partial counts are discarded so counting restarts at 0.
        w_cnt_nxt[i] = '0;
      end else if (r_s2[i] == r_stable[i]) begin
        // Agreement (including chatter back to the stable level) restarts.
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == LP_TERM) begin
        // Held long enough: adopt the new level and flag the direction.
        w_cnt_nxt[i]    = '0;
        w_stable_nxt[i] = r_s2[i];
        w_rise_nxt[i]   = r_s2[i];
        w_fall_nxt[i]   = ~r_s2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + LP_ONE;
      end
    end
    w_changed_nxt = |(w_rise_nxt | w_fall_nxt);
  end

  // Counter, debounced level and pulse registers; reset wins over acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_stable  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  assign sw_stable = r_stable;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign changed   = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4).
// A stimulus process drives one edge at a time and pushes the expected
// post-edge outputs from a run-length reference model; a monitor pops and
// compares on every falling edge. A few latency points are also checked
// directly against constants.
module tb_switch_debouncer;

  localparam int D = 4;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic       ch;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] sw_in;
  logic [7:0] sw_stable;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       changed;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: two-stage delay of the input, accepted level,
  // and the length of the current run of differing enabled cycles.
  logic [7:0] m_d1;
  logic [7:0] m_d2;
  logic [7:0] m_st;
  int         run[8];

  switch_debouncer #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .sw_in    (sw_in),
    .sw_stable(sw_stable),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .changed  (changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model one rising edge given the inputs present at that edge.
  task automatic model_edge(input logic r, input logic e, input logic [7:0] s);
    exp_t       x;
    logic [7:0] ri;
    logic [7:0] fa;
    ri = 8'h00;
    fa = 8'h00;
    if (r) begin
      m_d1 = 8'h00;
      m_d2 = 8'h00;
      m_st = 8'h00;
      for (int i = 0; i < 8; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (e && (m_d2[i] != m_st[i])) begin
          run[i] = run[i] + 1;
          if (run[i] == D) begin
            run[i]  = 0;
            m_st[i] = m_d2[i];
            if (m_d2[i]) ri[i] = 1'b1;
            else         fa[i] = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = s;
    end
    x.st = m_st;
    x.ri = ri;
    x.fa = fa;
    x.ch = |(ri | fa);
    sb.push_back(x);
  endtask

  // Drive inputs, take one edge, record expectation, return at the falling edge.
  task automatic step(input logic r, input logic e, input logic [7:0] s);
    rst   = r;
    ena   = e;
    sw_in = s;
    @(posedge clk);
    model_edge(r, e, s);
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic r, input logic e, input logic [7:0] s);
    for (int k = 0; k < n; k++) step(r, e, s);
  endtask

  // Monitor: every cycle presents outputs; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("sw_stable", sw_stable, x.st);
      chk("sw_rise",   sw_rise,   x.ri);
      chk("sw_fall",   sw_fall,   x.fa);
      chk("changed",   {7'd0, changed}, {7'd0, x.ch});
    end
  end

  initial begin
    logic [7:0] cur;
    logic [7:0] chat;
    rst   = 1'b1;
    ena   = 1'b1;
    sw_in = 8'h00;
    m_d1  = 8'h00;
    m_d2  = 8'h00;
    m_st  = 8'h00;
    for (int i = 0; i < 8; i++) run[i] = 0;

    // Reset state
    steps(3, 1'b1, 1'b1, 8'h00);
    chk("reset_stable", sw_stable, 8'h00);

    // Held rise on bit0: accepted after edge 6 with a single pulse
    steps(5, 1'b0, 1'b1, 8'h01);
    chk("lat_before", sw_stable, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    chk("lat_at6", sw_stable, 8'h01);
    chk("lat_rise", sw_rise, 8'h01);
    step(1'b0, 1'b1, 8'h01);
    chk("lat_rise_gone", sw_rise, 8'h00);
    steps(3, 1'b0, 1'b1, 8'h01);

    // Short glitch is ignored
    steps(2, 1'b1, 1'b1, 8'h00);
    steps(3, 1'b0, 1'b1, 8'h01);
    steps(10, 1'b0, 1'b1, 8'h00);
    chk("glitch_stable", sw_stable, 8'h00);

    // Two channels rise then fall together
    steps(10, 1'b0, 1'b1, 8'h03);
    steps(5, 1'b0, 1'b1, 8'h00);
    chk("fall_before", sw_fall, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("fall_at6", sw_fall, 8'h03);
    chk("fall_stable", sw_stable, 8'h00);
    steps(3, 1'b0, 1'b1, 8'h00);

    // Chatter on bit2: 1,1,1,0,1,1,1,1
    chat = 8'b1111_0111;
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, {5'd0, chat[k], 2'd0});
    steps(6, 1'b0, 1'b1, 8'h04);
    chk("chatter_stable", sw_stable, 8'h04);

    // Disabled for 20 cycles, then enabled: accepted 4 edges later
    steps(2, 1'b1, 1'b1, 8'h00);
    steps(20, 1'b0, 1'b0, 8'hFF);
    chk("dis_stable", sw_stable, 8'h00);
    steps(3, 1'b0, 1'b1, 8'hFF);
    chk("ena_before", sw_stable, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    chk("ena_at4", sw_stable, 8'hFF);
    chk("ena_rise", sw_rise, 8'hFF);

    // Reset mid-count discards progress; full 6 edges after release
    steps(2, 1'b1, 1'b1, 8'h00);
    steps(5, 1'b0, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h01);
    chk("rst_nopulse", sw_rise, 8'h00);
    steps(5, 1'b0, 1'b1, 8'h01);
    chk("rst_before", sw_stable, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    chk("rst_at6", sw_stable, 8'h01);

    // Randomized chatter, enable toggling and rare resets
    cur = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      logic r_v;
      logic e_v;
      if ($urandom_range(0, 9) == 0) cur = cur ^ 8'($urandom_range(0, 255));
      r_v = ($urandom_range(0, 299) == 0);
      e_v = ($urandom_range(0, 19) != 0);
      step(r_v, e_v, cur);
    end

    // Drain and confirm every expectation was consumed
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
